// File: rtl/gs_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gs_pkg : shared types and helpers for the iterative Gauss-Seidel/Jacobi solver
// Revision 1.0
// ----------------------------------------------------------------------------
package gs_pkg;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_MAC   = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam int MAXW = 128;
  typedef logic signed [MAXW-1:0] wide_t;

  // Accumulator width that holds b<<FW minus N-1 full-width products.
  function automatic int acc_width(input int n, input int dw, input int xw);
    return dw + xw + $clog2(n) + 1;
  endfunction

  function automatic wide_t sat_to(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (w - 1));
    res = v;
    if (v > hi)
      res = hi;
    else if (v < lo)
      res = lo;
    return res;
  endfunction

  function automatic int a_lsb(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  function automatic int v_lsb(input int r, input int w);
    return r * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gs_seq_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gs_seq_div : signed restoring divider, AW-bit dividend / DW-bit divisor
// Revision 1.0
// ----------------------------------------------------------------------------
module gs_seq_div #(
  parameter int AW = 51,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic signed [AW-1:0] dividend,
  input  logic signed [DW-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic signed [AW-1:0] quotient,
  output logic                 dz
);

  localparam int CW = $clog2(AW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] dvs;
  logic [AW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          neg;

  logic [DW-1:0] dvs_in;
  logic [DW-1:0] dvs_step;
  logic [DW-1:0] rem_in;
  logic [AW-1:0] quo_in;
  logic [DW:0]   sh;
  logic [DW:0]   diff;
  logic [DW-1:0] rem_nx;
  logic [AW-1:0] quo_nx;

  // The first quotient bit is resolved in the start cycle itself, so the
  // result is ready AW cycles after start with only AW-1 further steps.
  always_comb begin
    dvs_in = divisor[DW-1] ? -divisor : divisor;
    if (start) begin
      rem_in   = '0;
      quo_in   = dividend[AW-1] ? -dividend : dividend;
      dvs_step = dvs_in;
    end else begin
      rem_in   = rem;
      quo_in   = quo;
      dvs_step = dvs;
    end
    sh   = {rem_in, quo_in[AW-1]};
    diff = sh - {1'b0, dvs_step};
    if (!diff[DW]) begin
      rem_nx = diff[DW-1:0];
      quo_nx = {quo_in[AW-2:0], 1'b1};
    end else begin
      rem_nx = sh[DW-1:0];
      quo_nx = {quo_in[AW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      quo  <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= rem_nx;
      quo  <= quo_nx;
      dvs  <= dvs_in;
      neg  <= dividend[AW-1] ^ divisor[DW-1];
      dz   <= (divisor == '0);
      cnt  <= CW'(AW - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1))
        done <= 1'b1;
    end
  end

  assign busy     = (cnt != '0);
  assign quotient = neg ? -quo : quo;

endmodule
`default_nettype wire

// File: rtl/gs_solver_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gs_solver_param : iterative Ax=b solver (Gauss-Seidel / Jacobi), one MAC + seq divider
// Revision 1.0
// ----------------------------------------------------------------------------
module gs_solver_param #(
  parameter int N   = 16,
  parameter int DW  = 16,
  parameter int XW  = 32,
  parameter int FW  = 16,
  parameter int ITW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_module_en,
  input  logic              i_mode,
  input  logic [ITW-1:0]    i_iter,
  input  logic [N*N*DW-1:0] i_a,
  input  logic [N*DW-1:0]   i_b,
  output logic [N*XW-1:0]   o_x,
  output logic              o_done,
  output logic              o_err
);

  import gs_pkg::*;

  localparam int            ACCW = acc_width(N, DW, XW);
  localparam int            RW   = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  state_t state;
  state_t state_nx;

  logic signed [DW-1:0]   a_m    [N][N];
  logic signed [DW-1:0]   b_m    [N];
  logic signed [XW-1:0]   x      [N];
  logic signed [XW-1:0]   x_prev [N];
  logic                   mode_r;
  logic [ITW-1:0]         iter_r;
  logic [ITW-1:0]         sweep;
  logic [RW-1:0]          row;
  logic [RW-1:0]          col;
  logic signed [ACCW-1:0] acc;

  logic signed [XW-1:0]    xsrc;
  logic signed [DW+XW-1:0] a_ext;
  logic signed [DW+XW-1:0] x_ext;
  logic signed [DW+XW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  base;
  logic signed [ACCW-1:0]  acc_nx;
  logic signed [XW-1:0]    wval;
  logic signed [XW-1:0]    xnew;
  logic                    last_row;
  logic                    last_sweep;

  logic                   div_start;
  logic                   div_clr;
  logic                   div_busy;
  logic                   div_done;
  logic                   div_dz;
  logic signed [ACCW-1:0] div_q;

  // Jacobi reads the sweep-start snapshot, Gauss-Seidel the live vector.
  assign xsrc     = mode_r ? x_prev[col] : x[col];
  assign a_ext    = {{XW{a_m[row][col][DW-1]}}, a_m[row][col]};
  assign x_ext    = {{DW{xsrc[XW-1]}}, xsrc};
  assign prod     = a_ext * x_ext;
  assign prod_ext = {{(ACCW-DW-XW){prod[DW+XW-1]}}, prod};
  assign base     = {{(ACCW-DW-FW){b_m[row][DW-1]}}, b_m[row], {FW{1'b0}}};
  assign acc_nx   = ((col == '0) ? base : acc) - ((col == row) ? '0 : prod_ext);

  assign wval       = XW'(sat_to(wide_t'(div_q), XW));
  assign xnew       = div_dz ? '0 : wval;
  assign last_row   = (row == LAST);
  assign last_sweep = ((sweep + ITW'(1)) == iter_r);
  assign div_clr    = !i_module_en;

  gs_seq_div #(
    .AW (ACCW),
    .DW (DW)
  ) u_div (
    .clk      (i_clk),
    .rst      (i_reset),
    .clr      (div_clr),
    .start    (div_start),
    .dividend (acc_nx),
    .divisor  (a_m[row][row]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .dz       (div_dz)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state <= S_WAIT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      S_WAIT: begin
        if (i_module_en)
          state_nx = S_MAC;
      end
      S_MAC: begin
        if (!i_module_en)
          state_nx = S_WAIT;
        else if (iter_r == '0)
          state_nx = S_HOLD;   // zero sweeps: one pass through MAC, then done
        else if (col == LAST) begin
          state_nx  = S_DIV;
          div_start = 1'b1;
        end
      end
      S_DIV: begin
        if (!i_module_en)
          state_nx = S_WAIT;
        else if (div_done && !div_busy)
          state_nx = S_WRITE;
      end
      S_WRITE: begin
        if (!i_module_en)
          state_nx = S_WAIT;
        else if (last_row && last_sweep)
          state_nx = S_HOLD;
        else
          state_nx = S_MAC;
      end
      S_HOLD: begin
        if (!i_module_en)
          state_nx = S_WAIT;
      end
      default: state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < N; r++) begin
        x[r]      <= '0;
        x_prev[r] <= '0;
        b_m[r]    <= '0;
        for (int c = 0; c < N; c++)
          a_m[r][c] <= '0;
      end
      mode_r <= 1'b0;
      iter_r <= '0;
      sweep  <= '0;
      row    <= '0;
      col    <= '0;
      acc    <= '0;
      o_err  <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (i_module_en) begin
            for (int r = 0; r < N; r++) begin
              x[r]      <= '0;
              x_prev[r] <= '0;
              b_m[r]    <= i_b[v_lsb(r, DW) +: DW];
              for (int c = 0; c < N; c++)
                a_m[r][c] <= i_a[a_lsb(r, c, N, DW) +: DW];
            end
            mode_r <= i_mode;
            iter_r <= i_iter;
            sweep  <= '0;
            row    <= '0;
            col    <= '0;
            o_err  <= 1'b0;
          end
        end
        S_MAC: begin
          if (i_module_en) begin
            acc <= acc_nx;
            col <= (col == LAST) ? '0 : col + RW'(1);
          end
        end
        S_WRITE: begin
          if (i_module_en) begin
            x[row] <= xnew;
            if (div_dz)
              o_err <= 1'b1;
            if (last_row) begin
              row   <= '0;
              sweep <= sweep + ITW'(1);
              for (int r = 0; r < N; r++)
                x_prev[r] <= (RW'(r) == row) ? xnew : x[r];
            end else begin
              row <= row + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_out
    assign o_x[v_lsb(r, XW) +: XW] = x[r];
  end

  assign o_done = (state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_gs_solver_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gs_solver_param : directed self-checking bench, N=4 and N=2 instances
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_gs_solver_param;

  import gs_pkg::*;

  localparam int ROW4 = 4 + 51 + 1;   // N + ACCW + 1 with ACCW = 16+32+2+1
  localparam int ROW2 = 2 + 50 + 1;   // ACCW = 16+32+1+1

  logic clk;
  logic rst;

  logic         en4, mode4, done4, err4;
  logic [4:0]   iter4;
  logic [255:0] a4;
  logic [63:0]  b4;
  logic [127:0] x4;

  logic         en2, mode2, done2, err2;
  logic [4:0]   iter2;
  logic [63:0]  a2;
  logic [31:0]  b2;
  logic [63:0]  x2;

  int     checks   = 0;
  int     failures = 0;
  int     am [4][4];
  int     bm [4];
  longint xm [4];

  gs_solver_param #(.N(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_module_en(en4), .i_mode(mode4), .i_iter(iter4),
    .i_a(a4), .i_b(b4), .o_x(x4), .o_done(done4), .o_err(err4)
  );

  gs_solver_param #(.N(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_module_en(en2), .i_mode(mode2), .i_iter(iter2),
    .i_a(a2), .i_b(b2), .o_x(x2), .o_done(done2), .o_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    longint r;
    r = v;
    if (v > 64'sd2147483647)
      r = 64'sd2147483647;
    else if (v < -64'sd2147483648)
      r = -64'sd2147483648;
    return r;
  endfunction

  task automatic model4(input logic mode, input int iter);
    longint xp [4];
    longint acc;
    for (int i = 0; i < 4; i++) xm[i] = 0;
    for (int s = 0; s < iter; s++) begin
      for (int i = 0; i < 4; i++) xp[i] = xm[i];
      for (int r = 0; r < 4; r++) begin
        acc = longint'(bm[r]) * 65536;
        for (int c = 0; c < 4; c++)
          if (c != r) acc -= longint'(am[r][c]) * (mode ? xp[c] : xm[c]);
        xm[r] = sat32(acc / longint'(am[r][r]));
      end
    end
  endtask

  task automatic set2(input int a00, input int a01, input int a10, input int a11,
                      input int b0, input int b1);
    a2 = {16'(a11), 16'(a10), 16'(a01), 16'(a00)};
    b2 = {16'(b1), 16'(b0)};
  endtask

  task automatic run2(input logic mode, input int iter, input string tag);
    int n;
    int exp_n;
    exp_n = (iter == 0) ? 1 : iter * 2 * ROW2;
    mode2 = mode;
    iter2 = 5'(iter);
    en2   = 1'b1;
    @(posedge clk); #1;
    check({tag, ".err_clr"}, {63'b0, err2}, 64'd0);
    n = 0;
    while (!done2 && n < exp_n + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic stop2(input string tag);
    en2 = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_drop"}, {63'b0, done2}, 64'd0);
  endtask

  task automatic run4(input logic mode, input int iter, input string tag);
    int n;
    int exp_n;
    for (int r = 0; r < 4; r++) begin
      b4[r*16 +: 16] = 16'(bm[r]);
      for (int c = 0; c < 4; c++) a4[(r*4+c)*16 +: 16] = 16'(am[r][c]);
    end
    exp_n = iter * 4 * ROW4;
    mode4 = mode;
    iter4 = 5'(iter);
    en4   = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done4 && n < exp_n + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic stop4(input string tag);
    en4 = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_drop"}, {63'b0, done4}, 64'd0);
  endtask

  task automatic cmp4_model(input string tag);
    logic [31:0] e;
    for (int r = 0; r < 4; r++) begin
      e = xm[r][31:0];
      check($sformatf("%s.x%0d", tag, r), {32'b0, x4[r*32 +: 32]}, {32'b0, e});
    end
  endtask

  initial begin
    rst = 1'b1;
    en4 = 1'b0; mode4 = 1'b0; iter4 = '0; a4 = '0; b4 = '0;
    en2 = 1'b0; mode2 = 1'b0; iter2 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.x4", x4[63:0], 64'd0);
    check("rst.done4", {62'b0, done4, err4}, 64'd0);
    check("rst.x2", x2, 64'd0);
    check("rst.done2", {62'b0, done2, err2}, 64'd0);
    rst = 1'b0;

    // diagonal system, exact latency
    for (int r = 0; r < 4; r++) begin
      bm[r] = 2 * (r + 1);
      for (int c = 0; c < 4; c++) am[r][c] = (r == c) ? 2 : 0;
    end
    run4(1'b0, 1, "diag");
    check("diag.x0", {32'b0, x4[31:0]},   64'h0001_0000);
    check("diag.x1", {32'b0, x4[63:32]},  64'h0002_0000);
    check("diag.x2", {32'b0, x4[95:64]},  64'h0003_0000);
    check("diag.x3", {32'b0, x4[127:96]}, 64'h0004_0000);
    stop4("diag");

    set2(4, 1, 1, 3, 1, 2);
    run2(1'b0, 1, "gs2");
    check("gs2.x0", {32'b0, x2[31:0]},  64'h0000_4000);
    check("gs2.x1", {32'b0, x2[63:32]}, 64'h0000_9555);
    stop2("gs2");

    run2(1'b1, 1, "jac2");
    check("jac2.x0", {32'b0, x2[31:0]},  64'h0000_4000);
    check("jac2.x1", {32'b0, x2[63:32]}, 64'h0000_AAAA);
    stop2("jac2");

    // zero diagonal, then the next start must clear o_err
    set2(4, 1, 1, 0, 1, 2);
    run2(1'b0, 1, "zd");
    check("zd.x0", {32'b0, x2[31:0]},  64'h0000_4000);
    check("zd.x1", {32'b0, x2[63:32]}, 64'h0);
    check("zd.err", {63'b0, err2}, 64'd1);
    stop2("zd");
    set2(4, 1, 1, 3, 1, 2);
    run2(1'b0, 1, "zd_clr");
    check("zd_clr.err", {63'b0, err2}, 64'd0);
    stop2("zd_clr");

    // saturation at both rails
    set2(1, 0, -32768, 1, 32767, 32767);
    run2(1'b0, 1, "satp");
    check("satp.x0", {32'b0, x2[31:0]},  64'h7FFF_0000);
    check("satp.x1", {32'b0, x2[63:32]}, 64'h7FFF_FFFF);
    stop2("satp");
    set2(1, 0, 32767, 1, 32767, -32768);
    run2(1'b0, 1, "satn");
    check("satn.x1", {32'b0, x2[63:32]}, 64'h8000_0000);
    stop2("satn");

    // zero sweeps
    set2(4, 1, 1, 3, 1, 2);
    run2(1'b0, 0, "it0");
    check("it0.x", x2, 64'd0);
    stop2("it0");

    // abort mid-divide, then restart from scratch
    mode2 = 1'b0; iter2 = 5'd1; en2 = 1'b1;
    @(posedge clk); #1;
    repeat (12) @(posedge clk);
    #1;
    check("abort.in_div", 64'(u_dut2.state), 64'(S_DIV));
    en2 = 1'b0;
    @(posedge clk); #1;
    check("abort.state", 64'(u_dut2.state), 64'(S_WAIT));
    check("abort.done", {63'b0, done2}, 64'd0);
    run2(1'b0, 1, "restart");
    check("restart.x0", {32'b0, x2[31:0]},  64'h0000_4000);
    check("restart.x1", {32'b0, x2[63:32]}, 64'h0000_9555);
    stop2("restart");

    // diagonally dominant system against the reference model, both modes
    am = '{'{10, 2, -1, 3}, '{-2, 12, 4, 1}, '{1, -3, 9, 2}, '{2, 1, -2, 8}};
    bm = '{7, -5, 12, 3};
    for (int m = 0; m < 2; m++) begin
      model4(m[0], 16);
      run4(m[0], 16, $sformatf("dd%0d", m));
      cmp4_model($sformatf("dd%0d", m));
      check($sformatf("dd%0d.err", m), {63'b0, err4}, 64'd0);
      stop4($sformatf("dd%0d", m));
    end

    // asynchronous reset during the second row's MAC phase
    for (int r = 0; r < 4; r++) begin
      bm[r] = 2 * (r + 1);
      for (int c = 0; c < 4; c++) am[r][c] = (r == c) ? 2 : 0;
      b4[r*16 +: 16] = 16'(bm[r]);
      for (int c = 0; c < 4; c++) a4[(r*4+c)*16 +: 16] = 16'(am[r][c]);
    end
    mode4 = 1'b0; iter4 = 5'd1; en4 = 1'b1;
    @(posedge clk); #1;
    repeat (ROW4 + 2) @(posedge clk);
    #1;
    check("mid.x0_visible", {32'b0, x4[31:0]}, 64'h0001_0000);
    #2 rst = 1'b1;
    #1;
    check("arst.x4", x4[63:0], 64'd0);
    check("arst.flags", {62'b0, done4, err4}, 64'd0);
    check("arst.state", 64'(u_dut4.state), 64'(S_WAIT));
    en4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gs_solver_param.md
Name: gs_solver_param

Overview:
- Parametrised iterative linear-system solver for Ax = b with one MAC and one sequential divider, giving an area-efficient successor to the fixed 16x16 combinational solver.
- Supports runtime iteration count and Gauss-Seidel or Jacobi mode, plus divide-by-zero detection.
- Sits behind the top-level controller; uses the same i_module_en / o_done level handshake.

Parameters:
N, 16, matrix dimension (N >= 2)
DW, 16, signed integer width of each A and b element
XW, 32, signed fixed-point width of each x element
FW, 16, fractional bits of x (x is S(XW-FW-1).FW)
ITW, 5, width of iteration-count input

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_module_en  in  1  level start/hold request
i_mode  in  1  0 = Gauss-Seidel, 1 = Jacobi; sampled at start
i_iter  in  ITW  number of sweeps; sampled at start
i_a  in  N*N*DW  A row-major; element (r,c) at bits [(r*N+c)*DW +: DW]
i_b  in  N*DW  b; element r at bits [r*DW +: DW]
o_x  out  N*XW  solution; element r at bits [r*XW +: XW]
o_done  out  1  result valid
o_err  out  1  sticky: a zero diagonal was seen in this run

Behaviour:
- Interface: one clock i_clk. Reset i_reset is asynchronous, active-high. Reset clears all state.
- Reset values: o_x = 0, o_done = 0, o_err = 0, state = WAIT.
- States and transitions:
  - WAIT: when i_module_en = 1, latch i_a, i_b, i_mode and i_iter in the same edge. Clear x, o_err and o_done. Set row = 0 and sweep = 0. Go to MAC. If i_iter = 0, go straight to HOLD with x = 0 and o_done = 1 on the next cycle.
  - MAC: N cycles, col = 0..N-1.
    - acc starts at sext(b_row) << FW.
    - For col != row: acc -= a(row,col) * xsrc(col).
    - xsrc is the live x register in Gauss-Seidel mode. In Jacobi mode it is the x_prev snapshot taken at the start of each sweep.
    - col == row contributes nothing.
  - DIV: start the divider with acc / a(row,row). The divider takes ACCW cycles, where ACCW = DW+XW+clog2(N)+1.
  - WRITE (1 cycle): saturate the quotient to signed XW and store it to x[row].
    - If a(row,row) = 0: store 0 instead and set o_err.
    - If row = N-1: row = 0 and sweep++. If sweep+1 = iter, go to HOLD; otherwise copy x into x_prev and go to MAC.
    - Otherwise: row++ and go to MAC.
  - HOLD: o_done = 1 and o_x is stable. When i_module_en = 0, clear o_done and go to WAIT.
- Run length: total = iter*N*(N+ACCW+1) cycles after the start edge. Defaults give 70 cycles per row.
- Arithmetic:
  - acc is signed ACCW bits and never overflows.
  - Division is signed and truncates toward zero.
  - Saturation clamps to [-2^(XW-1), 2^(XW-1)-1].
- o_x: continuously shows the x register, so partial values are visible mid-run. Only o_done qualifies the result.
- Abort: if i_module_en falls in MAC, DIV or WRITE, go to WAIT next cycle. o_done stays 0, x keeps its partial value, the divider is flushed.
- New request: a rising i_module_en in WAIT always reloads all inputs. Inputs that change during a run are ignored.
- Reset mid-operation: immediate return to the reset values, with no output glitch beyond the reset.

Decomposition:
- Package gs_pkg holds:
  - the state typedef (WAIT, MAC, DIV, WRITE, HOLD);
  - a function for ACCW;
  - a saturation function;
  - element-slice helper functions.
- Sub-module gs_seq_div: signed sequential restoring divider, ACCW-bit dividend and DW-bit divisor.
  - Ports: start, busy, done, quotient, dz.
  - Fixed ACCW-cycle latency.
  - Flushed by a synchronous clear input.

Test Plan:
- N=4, A=diag(2,2,2,2), b=[2,4,6,8], iter=1, GS -> o_x = [0x00010000, 0x00020000, 0x00030000, 0x00040000]; o_done rises exactly 4*(4+ACCW+1) cycles after the start edge.
- N=2, A=[[4,1],[1,3]], b=[1,2], iter=1, GS -> x0 = 0x00004000, x1 = 0x00009555. Same stimulus in Jacobi mode -> x0 = 0x00004000, x1 = 0x0000AAAA.
- N=4, diagonally dominant random A, iter=16, both modes -> matches bit-exact reference model; o_err = 0.
- N=2, a(1,1) = 0 -> x1 = 0, o_err = 1, o_done = 1; o_err clears on the next start.
- iter = 0 -> o_done = 1 two cycles after the start, o_x = 0. Then drop i_module_en -> o_done = 0 next cycle.
- Abort by dropping i_module_en mid-DIV, then restart -> correct result, identical to an uninterrupted run. Assert i_reset mid-MAC -> all outputs 0 asynchronously, state = WAIT.
